// File: rtl/step_scheduler.sv
// Step scheduler: sequences verlet, distance-constraint and fix grants over a mass-spring chain.
// Latency: first grant one cycle after start is accepted; each grant retires on the edge its done is seen.
// Backpressure: a grant holds until acknowledged; with STEP_SCHED_WATCHDOG_EN it is forced off after 256 cycles.
module step_scheduler #(
    parameter int NODES = 5,
    parameter int ITERS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NODES-1:0] fixed_mask,
    input  logic [NODES-1:0] node_done,
    input  logic [NODES-2:0] link_done,
    output logic [NODES-1:0] verlet_state,
    output logic [NODES-2:0] link_state,
    output logic [NODES-1:0] fix_state,
    output logic             busy,
    output logic             step_done,
    output logic [31:0]      step_count,
    output logic             timeout_err
);

    localparam int PW = (NODES > 2) ? $clog2(NODES) : 1;
    localparam int LW = NODES - 1;
    localparam logic [PW-1:0] LAST_NODE = PW'(NODES - 1);
    localparam logic [PW-1:0] LAST_LINK = PW'(NODES - 2);
    localparam logic [3:0]    LAST_PASS = 4'(ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VERLET,
        S_CONSTRAIN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [3:0]       pass_q, pass_d;
    logic [NODES-1:0] mask_q, mask_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [NODES-1:0] verlet_q, verlet_d;
    logic [LW-1:0]    link_q, link_d;
    logic [NODES-1:0] fix_q, fix_d;
    logic             busy_q, busy_d;
    logic             sdone_q, sdone_d;

    logic             granted;
    logic             ack;
    logic             advance;
    logic             expire;
    logic [NODES-1:0] link_done_ext;

    // Widen so one pointer can index nodes and links alike.
    assign link_done_ext = {1'b0, link_done};

`ifdef STEP_SCHED_WATCHDOG_EN
    logic [7:0] wd_q, wd_d;
    logic       to_q, to_d;
    assign expire      = granted && !ack && (wd_q == 8'hFF);
    assign timeout_err = to_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pass_d  = pass_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        granted = 1'b0;
        ack     = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = fixed_mask;
                    state_d = S_VERLET;
                    ptr_d   = '0;
                    pass_d  = '0;
                end
            end
            S_VERLET: begin
                granted = !mask_q[ptr_q];
                ack     = node_done[ptr_q];
                advance = !granted || ack || expire;
                if (advance) begin
                    if (ptr_q == LAST_NODE) begin
                        state_d = S_CONSTRAIN;
                        ptr_d   = '0;
                        pass_d  = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            S_CONSTRAIN: begin
                granted = 1'b1;
                ack     = link_done_ext[ptr_q];
                advance = ack || expire;
                if (advance) begin
                    if (ptr_q != LAST_LINK) begin
                        ptr_d = ptr_q + 1'b1;
                    end else if (pass_q == LAST_PASS) begin
                        state_d = S_FIX;
                        ptr_d   = '0;
                    end else begin
                        pass_d = pass_q + 1'b1;
                        ptr_d  = '0;
                    end
                end
            end
            S_FIX: begin
                granted = mask_q[ptr_q];
                ack     = node_done[ptr_q];
                advance = !granted || ack || expire;
                if (advance) begin
                    if (ptr_q == LAST_NODE) begin
                        state_d = S_DONE;
                        ptr_d   = '0;
                        cnt_d   = cnt_q + 32'd1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Grants are registered, so decode them from the next state.
        verlet_d = '0;
        link_d   = '0;
        fix_d    = '0;
        if (state_d == S_VERLET && !mask_d[ptr_d]) verlet_d = NODES'(1) << ptr_d;
        if (state_d == S_CONSTRAIN)                link_d   = LW'(1) << ptr_d;
        if (state_d == S_FIX && mask_d[ptr_d])     fix_d    = NODES'(1) << ptr_d;
        busy_d  = (state_d != S_IDLE);
        sdone_d = (state_d == S_DONE);
    end

`ifdef STEP_SCHED_WATCHDOG_EN
    always_comb begin
        wd_d = wd_q;
        to_d = to_q | expire;
        if (advance)      wd_d = '0;
        else if (granted) wd_d = wd_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            pass_q   <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            verlet_q <= '0;
            link_q   <= '0;
            fix_q    <= '0;
            busy_q   <= 1'b0;
            sdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            pass_q   <= pass_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            verlet_q <= verlet_d;
            link_q   <= link_d;
            fix_q    <= fix_d;
            busy_q   <= busy_d;
            sdone_q  <= sdone_d;
        end
    end

    assign verlet_state = verlet_q;
    assign link_state   = link_q;
    assign fix_state    = fix_q;
    assign busy         = busy_q;
    assign step_done    = sdone_q;
    assign step_count   = cnt_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Scoreboard bench for step_scheduler (NODES=5, ITERS=2): expected per-cycle words queued by stimulus.
module tb_step_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  fixed_mask = '0;
    logic [4:0]  node_done = 5'h1F;
    logic [3:0]  link_done = 4'hF;
    logic [4:0]  verlet_state;
    logic [3:0]  link_state;
    logic [4:0]  fix_state;
    logic        busy;
    logic        step_done;
    logic [31:0] step_count;
    logic        timeout_err;

    typedef struct packed {
        logic [4:0]  v;
        logic [3:0]  l;
        logic [4:0]  f;
        logic        sd;
        logic        to;
        logic [31:0] cnt;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        mon_act, mon_exp;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;
    logic        exp_to = 1'b0;

    step_scheduler #(.NODES(5), .ITERS(2)) dut (
        .clk(clk), .reset(rst_n), .start(start), .fixed_mask(fixed_mask),
        .node_done(node_done), .link_done(link_done),
        .verlet_state(verlet_state), .link_state(link_state), .fix_state(fix_state),
        .busy(busy), .step_done(step_done), .step_count(step_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Monitor: one expected word per busy cycle.
    always @(negedge clk) begin
        if (busy) begin
            mon_act = '{v: verlet_state, l: link_state, f: fix_state, sd: step_done,
                        to: timeout_err, cnt: step_count};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, expected nothing", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL step_word @%0t: got v=%b l=%b f=%b sd=%b to=%b cnt=%0d, expected v=%b l=%b f=%b sd=%b to=%b cnt=%0d",
                             $time, mon_act.v, mon_act.l, mon_act.f, mon_act.sd, mon_act.to, mon_act.cnt,
                             mon_exp.v, mon_exp.l, mon_exp.f, mon_exp.sd, mon_exp.to, mon_exp.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Reference model of one full step.
    task automatic push_step(input logic [4:0] mask, input int n2_extra, input int l0_extra,
                             input bit l0_timeout);
        obs_t w;
        int   reps;
        for (int i = 0; i < 5; i++) begin
            w = '0; w.cnt = exp_cnt; w.to = exp_to;
            if (!mask[i]) w.v = 5'(1 << i);
            reps = (i == 2 && !mask[i]) ? 1 + n2_extra : 1;
            repeat (reps) exp_q.push_back(w);
        end
        for (int p = 0; p < 2; p++) begin
            for (int l = 0; l < 4; l++) begin
                w = '0; w.cnt = exp_cnt; w.to = exp_to; w.l = 4'(1 << l);
                reps = (p == 0 && l == 0) ? 1 + l0_extra : 1;
                repeat (reps) exp_q.push_back(w);
                if (p == 0 && l == 0 && l0_timeout) exp_to = 1'b1;
            end
        end
        for (int i = 0; i < 5; i++) begin
            w = '0; w.cnt = exp_cnt; w.to = exp_to;
            if (mask[i]) w.f = 5'(1 << i);
            exp_q.push_back(w);
        end
        exp_cnt = exp_cnt + 1;
        w = '0; w.sd = 1'b1; w.cnt = exp_cnt; w.to = exp_to;
        exp_q.push_back(w);
    endtask

    task automatic do_start(input logic [4:0] mask);
        @(negedge clk);
        fixed_mask = mask;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if (step_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no step_done, expected one within 2000 cycles", name);
        end
        @(negedge clk);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #3;
        check("reset_grants", {49'd0, verlet_state, link_state, fix_state, busy, step_done}, 64'd0);
        check("reset_count", {32'd0, step_count}, 64'd0);
        check("reset_timeout", {63'd0, timeout_err}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Plain step; a start pulse mid-step is ignored.
        push_step(5'b00000, 0, 0, 0);
        do_start(5'b00000);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("plain");

        // Node 0 pinned; mask changes after accept have no effect.
        push_step(5'b00001, 0, 0, 0);
        do_start(5'b00001);
        fixed_mask = 5'b11110;
        wait_done("pinned");

        // Node 2 acknowledges late; ungranted node 3 pulses meanwhile.
        node_done = 5'b10011;
        push_step(5'b00000, 3, 0, 0);
        do_start(5'b00000);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 node_done[3] = 1'b1;
        @(posedge clk);
        #1 node_done[3] = 1'b0;
        @(posedge clk);
        #1 node_done = 5'h1F;
        wait_done("late_ack");

        // Reset during constraint pass 1 abandons the step.
        push_step(5'b00000, 0, 0, 0);
        do_start(5'b00000);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_grants", {49'd0, verlet_state, link_state, fix_state, busy, step_done}, 64'd0);
        check("midreset_count", {32'd0, step_count}, 64'd0);
        check("midreset_words_consumed", 64'(exp_q.size()), 64'd9);
        exp_q.delete();
        exp_cnt = 0;
        exp_to = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_step(5'b00000, 0, 0, 0);
        do_start(5'b00000);
        wait_done("after_reset");

        // Link 0 never acknowledged on its own.
        link_done = 4'b1110;
`ifdef STEP_SCHED_WATCHDOG_EN
        push_step(5'b00000, 0, 255, 1);
        do_start(5'b00000);
        wait_done("watchdog");
        link_done = 4'hF;
`else
        push_step(5'b00000, 0, 300, 0);
        do_start(5'b00000);
        repeat (305) @(posedge clk);
        #1 link_done = 4'hF;
        wait_done("long_hold");
`endif
        check("idle_timeout_flag", {63'd0, timeout_err}, {63'd0, exp_to});
        check("final_count", {32'd0, step_count}, {32'd0, exp_cnt});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000ns");
        $fatal(1, "bench time limit");
    end

endmodule
